pcie_symbol_sched: RTL and testbench
====================================

Name: pcie_symbol_sched

Overview:
- Symbol-select sequencer for the PCIe symbol multiplexer.
- Drives the 4-bit CTRL select that picks one of the ten 8-bit symbol inputs (TLP, COM, PAD, SKP, STP, SDP, END, EDB, FTS, IDL) every CLK_2MHz cycle.
- Frames requester TLPs as STP + payload + END, inserts periodic SKP ordered sets (COM + SKP×N) and fills all other cycles with IDL.

Parameters:
- SKP_INTERVAL, 16, cycles between SKP ordered-set requests (≥ 8).
- SKP_COUNT, 3, SKP symbols following COM in one ordered set (1..7).
- LEN_W, 8, width of TLP payload length in symbols.

Ports:
- CLK_2MHz  in  1  single block clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ENB  in  1  scheduler enable; sampled only at decision points.
- tlp_req  in  1  requester has a TLP; held with tlp_len until tlp_ack.
- tlp_len  in  LEN_W  payload symbols; 0 treated as 1.
- tlp_ack  out  1  one-cycle pulse, coincident with STP on IN_CTRL.
- tlp_rd  out  1  high on each payload cycle; requester advances its IN_TLP byte.
- IN_CTRL  out  4  mux select: 0 TLP, 1 COM, 2 PAD, 3 SKP, 4 STP, 5 SDP, 6 END, 7 EDB, 8 FTS, 9 IDL.
- sym_k  out  1  1 when IN_CTRL selects a control symbol (anything but 0).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs registered. Reset values: IN_CTRL=9, sym_k=1, tlp_ack=0, tlp_rd=0, busy=0, FSM=IDLE, skp_cnt=0, skp_pend=0.
- FSM states:
  - IDLE: emits IDL.
  - STP: one cycle.
  - PAYLOAD: tlp_len cycles, tlp_rd=1.
  - END: one cycle.
  - SKP_COM: one cycle.
  - SKP_SKP: SKP_COUNT cycles.
- Decision points are the IDLE state and the final cycle of END or of SKP_SKP. Next state at a decision point:
  - ENB=0 → IDLE.
  - else skp_pend=1 → SKP_COM.
  - else tlp_req=1 → STP.
  - else → IDLE.
- Back-to-back TLPs have no idle gap.
- SKP takes priority over a simultaneous tlp_req; the TLP is serviced at the next decision point.
- tlp_len is latched on the edge entering STP into a down-counter. PAYLOAD exits to END on the edge after the counter reaches 1.
- skp_cnt:
  - Increments every cycle with ENB=1, including mid-packet; frozen when ENB=0.
  - At SKP_INTERVAL-1 it wraps to 0 and sets skp_pend.
  - skp_pend clears on entry to SKP_COM. Pends do not accumulate; a second wrap while pending is dropped.
- A TLP or an ordered set in progress is never interrupted by SKP or by ENB deassert; it completes.
- reset mid-operation: immediate return to reset values. Any partial packet is lost and no END is emitted.
- tlp_len change while tlp_req=1 and before tlp_ack: protocol violation, behaviour undefined.

Optional Feature:
- Macro PCIE_NULLIFY_EN.
- Defined: adds input tlp_abort (1 bit), sampled during PAYLOAD. If it is seen high on any payload cycle, the terminating symbol is EDB (7) instead of END (6). Payload length is unchanged.
- Undefined: the port is absent and termination is always END.

Decomposition:
- Shared package pcie_sym_pkg holds:
  - the 4-bit symbol-select constants (SEL_TLP=0 … SEL_IDL=9);
  - the FSM state enum;
  - the K-code byte constants used by the mux: COM F2, PAD C7, SKP AC, STP AA, SDP E5, END F6, EDB DF, FTS A8, IDL AE.
- One sub-module, pcie_skp_timer: skp_cnt plus the skp_pend set/clear logic.

Test Plan:
- Reset: assert reset mid-cycle → IN_CTRL=9, busy=0, tlp_ack=0 immediately (asynchronous). Outputs hold until the first edge after release.
- Single TLP: ENB=1, tlp_req=1, tlp_len=3 → IN_CTRL sequence 4,0,0,0,6,9. tlp_ack high only in the STP cycle; tlp_rd high for exactly 3 cycles.
- Back-to-back: tlp_req held, len 2 then len 1 → 4,0,0,6,4,0,6 with no IDL between packets.
- SKP insertion: SKP_INTERVAL=16, no requests → 1,3,3,3 starts at the decision point after the 16th enabled cycle, repeating every 16 cycles.
- Collision: skp_pend=1 and tlp_req=1 at the same decision → 1,3,3,3 then 4,…; tlp_ack is delayed by 4 cycles. A SKP due mid-payload is deferred until after END.
- Nullify (PCIE_NULLIFY_EN): len 4 with tlp_abort pulsed on payload cycle 2 → 4,0,0,0,0,7.

Source files
------------

// File: rtl/pcie_sym_pkg.sv
// Shared symbol-select codes, K-code bytes and scheduler state encoding for the
// PCIe symbol multiplexer.
package pcie_sym_pkg;

    localparam int unsigned SEL_W = 4;
    localparam int unsigned SYM_W = 8;

    // Mux select codes driven on IN_CTRL
    localparam logic [SEL_W-1:0] SEL_TLP = 4'd0;
    localparam logic [SEL_W-1:0] SEL_COM = 4'd1;
    localparam logic [SEL_W-1:0] SEL_PAD = 4'd2;
    localparam logic [SEL_W-1:0] SEL_SKP = 4'd3;
    localparam logic [SEL_W-1:0] SEL_STP = 4'd4;
    localparam logic [SEL_W-1:0] SEL_SDP = 4'd5;
    localparam logic [SEL_W-1:0] SEL_END = 4'd6;
    localparam logic [SEL_W-1:0] SEL_EDB = 4'd7;
    localparam logic [SEL_W-1:0] SEL_FTS = 4'd8;
    localparam logic [SEL_W-1:0] SEL_IDL = 4'd9;

    // K-code bytes presented on the mux inputs
    localparam logic [SYM_W-1:0] K_COM = 8'hF2;
    localparam logic [SYM_W-1:0] K_PAD = 8'hC7;
    localparam logic [SYM_W-1:0] K_SKP = 8'hAC;
    localparam logic [SYM_W-1:0] K_STP = 8'hAA;
    localparam logic [SYM_W-1:0] K_SDP = 8'hE5;
    localparam logic [SYM_W-1:0] K_END = 8'hF6;
    localparam logic [SYM_W-1:0] K_EDB = 8'hDF;
    localparam logic [SYM_W-1:0] K_FTS = 8'hA8;
    localparam logic [SYM_W-1:0] K_IDL = 8'hAE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STP,
        ST_PAYLOAD,
        ST_END,
        ST_SKP_COM,
        ST_SKP_SKP
    } sched_state_e;

    function automatic logic sel_is_k(input logic [SEL_W-1:0] sel);
        return sel != SEL_TLP;
    endfunction

endpackage

// File: rtl/pcie_skp_timer.sv
// SKP ordered-set interval timer: counts enabled cycles and raises a single,
// non-accumulating pending flag each time the interval elapses.
module pcie_skp_timer
    import pcie_sym_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enb,
    input  logic clr,
    output logic skp_pend
);

    localparam int unsigned CNT_W = $clog2(SKP_INTERVAL);

    logic [CNT_W-1:0] skp_cnt;
    logic             wrap_c;

    assign wrap_c = enb && (skp_cnt == CNT_W'(SKP_INTERVAL - 1));

    // A wrap landing on the same edge as the clear starts a fresh pend
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skp_cnt  <= '0;
            skp_pend <= 1'b0;
        end else begin
            if (enb) begin
                skp_cnt <= wrap_c ? '0 : skp_cnt + CNT_W'(1);
            end
            if (wrap_c) begin
                skp_pend <= 1'b1;
            end else if (clr) begin
                skp_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcie_symbol_sched.sv
// Symbol-select sequencer: frames TLPs as STP/payload/END, inserts SKP ordered
// sets and fills with IDL. Define PCIE_NULLIFY_EN to add tlp_abort (END -> EDB).
module pcie_symbol_sched
    import pcie_sym_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 16,
    parameter int unsigned SKP_COUNT    = 3,
    parameter int unsigned LEN_W        = 8
) (
    input  logic             CLK_2MHz,
    input  logic             reset,
    input  logic             ENB,
    input  logic             tlp_req,
    input  logic [LEN_W-1:0] tlp_len,
`ifdef PCIE_NULLIFY_EN
    input  logic             tlp_abort,
`endif
    output logic             tlp_ack,
    output logic             tlp_rd,
    output logic [SEL_W-1:0] IN_CTRL,
    output logic             sym_k,
    output logic             busy
);

    localparam int unsigned SKPC_W = 3;

    sched_state_e      state, state_nxt;
    logic [LEN_W-1:0]  len_cnt, len_cnt_nxt;
    logic [SKPC_W-1:0] skp_left, skp_left_nxt;
    logic              aborted, aborted_nxt;
    logic              decide_c;
    logic              abort_c;
    logic              skp_pend;
    logic              skp_clr_c;
    logic [SEL_W-1:0]  sel_nxt;

`ifdef PCIE_NULLIFY_EN
    assign abort_c = tlp_abort;
`else
    assign abort_c = 1'b0;
`endif

    assign skp_clr_c = (state_nxt == ST_SKP_COM);

    pcie_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk     (CLK_2MHz),
        .reset   (reset),
        .enb     (ENB),
        .clr     (skp_clr_c),
        .skp_pend(skp_pend)
    );

    // Next state, counters and the select for the coming cycle
    always_comb begin
        state_nxt    = state;
        len_cnt_nxt  = len_cnt;
        skp_left_nxt = skp_left;
        aborted_nxt  = aborted;
        decide_c     = 1'b0;
        sel_nxt      = SEL_IDL;

        case (state)
            ST_IDLE:    decide_c = 1'b1;
            ST_STP:     state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: begin
                if (abort_c) begin
                    aborted_nxt = 1'b1;
                end
                if (len_cnt == LEN_W'(1)) begin
                    state_nxt = ST_END;
                end else begin
                    len_cnt_nxt = len_cnt - LEN_W'(1);
                end
            end
            ST_END:     decide_c = 1'b1;
            ST_SKP_COM: state_nxt = ST_SKP_SKP;
            ST_SKP_SKP: begin
                if (skp_left == SKPC_W'(1)) begin
                    decide_c = 1'b1;
                end else begin
                    skp_left_nxt = skp_left - SKPC_W'(1);
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase

        // Decision point: ordered set beats a waiting TLP
        if (decide_c) begin
            if (!ENB) begin
                state_nxt = ST_IDLE;
            end else if (skp_pend) begin
                state_nxt    = ST_SKP_COM;
                skp_left_nxt = SKPC_W'(SKP_COUNT);
            end else if (tlp_req) begin
                state_nxt   = ST_STP;
                len_cnt_nxt = (tlp_len == '0) ? LEN_W'(1) : tlp_len;
                aborted_nxt = 1'b0;
            end else begin
                state_nxt = ST_IDLE;
            end
        end

        case (state_nxt)
            ST_IDLE:    sel_nxt = SEL_IDL;
            ST_STP:     sel_nxt = SEL_STP;
            ST_PAYLOAD: sel_nxt = SEL_TLP;
            ST_END:     sel_nxt = aborted_nxt ? SEL_EDB : SEL_END;
            ST_SKP_COM: sel_nxt = SEL_COM;
            ST_SKP_SKP: sel_nxt = SEL_SKP;
            default:    sel_nxt = SEL_IDL;
        endcase
    end

    // Outputs are registered decodes of the state being entered
    always_ff @(posedge CLK_2MHz or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            len_cnt  <= '0;
            skp_left <= '0;
            aborted  <= 1'b0;
            IN_CTRL  <= SEL_IDL;
            sym_k    <= 1'b1;
            tlp_ack  <= 1'b0;
            tlp_rd   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            len_cnt  <= len_cnt_nxt;
            skp_left <= skp_left_nxt;
            aborted  <= aborted_nxt;
            IN_CTRL  <= sel_nxt;
            sym_k    <= sel_is_k(sel_nxt);
            tlp_ack  <= (state_nxt == ST_STP);
            tlp_rd   <= (state_nxt == ST_PAYLOAD);
            busy     <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_pcie_symbol_sched.sv
// Self-checking bench for pcie_symbol_sched: directed framing/SKP scenarios plus
// randomized traffic against a symbol-stream reference model.
module tb_pcie_symbol_sched;
    import pcie_sym_pkg::*;

    localparam int unsigned SKP_INTERVAL = 16;
    localparam int unsigned SKP_COUNT    = 3;
    localparam int unsigned LEN_W        = 8;

    logic             clk;
    logic             reset;
    logic             ENB;
    logic             tlp_req;
    logic [LEN_W-1:0] tlp_len;
`ifdef PCIE_NULLIFY_EN
    logic             tlp_abort;
`endif
    logic             tlp_ack;
    logic             tlp_rd;
    logic [3:0]       IN_CTRL;
    logic             sym_k;
    logic             busy;

    pcie_symbol_sched #(
        .SKP_INTERVAL(SKP_INTERVAL),
        .SKP_COUNT   (SKP_COUNT),
        .LEN_W       (LEN_W)
    ) dut (
        .CLK_2MHz (clk),
        .reset    (reset),
        .ENB      (ENB),
        .tlp_req  (tlp_req),
        .tlp_len  (tlp_len),
`ifdef PCIE_NULLIFY_EN
        .tlp_abort(tlp_abort),
`endif
        .tlp_ack  (tlp_ack),
        .tlp_rd   (tlp_rd),
        .IN_CTRL  (IN_CTRL),
        .sym_k    (sym_k),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of symbols still owed by the current frame
    int plan[$];
    int exp_sym;
    int m_cnt;
    bit m_pend;
    bit m_abort;

    int len_q[$];
    int obs[$];
    bit rnd_mode;

    localparam int EXP_SINGLE [6] = '{4, 0, 0, 0, 6, 9};
    localparam int EXP_B2B    [7] = '{4, 0, 0, 6, 4, 0, 6};
    localparam int EXP_NULL   [6] = '{4, 0, 0, 0, 0, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_obs(input string tag, input int idx, input int exp);
        if (idx >= obs.size()) check(tag, 32'hFFFF_FFFF, 32'(exp));
        else                   check(tag, 32'(obs[idx]), 32'(exp));
    endtask

    task automatic model_reset();
        plan.delete();
        exp_sym = 9;
        m_cnt   = 0;
        m_pend  = 0;
        m_abort = 0;
    endtask

    // One rising edge of the reference: pick the next frame when nothing is owed
    task automatic model_edge();
        int n;
`ifdef PCIE_NULLIFY_EN
        if (exp_sym == 0 && tlp_abort) m_abort = 1;
`endif
        if (plan.size() == 0) begin
            if (!ENB) begin
                plan.push_back(9);
            end else if (m_pend) begin
                plan.push_back(1);
                for (int i = 0; i < int'(SKP_COUNT); i++) plan.push_back(3);
                m_pend = 0;
            end else if (tlp_req) begin
                n = (int'(tlp_len) == 0) ? 1 : int'(tlp_len);
                plan.push_back(4);
                for (int i = 0; i < n; i++) plan.push_back(0);
                plan.push_back(6);
                m_abort = 0;
            end else begin
                plan.push_back(9);
            end
        end
        exp_sym = plan.pop_front();
        if (exp_sym == 6 && m_abort) exp_sym = 7;
        if (ENB) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == int'(SKP_INTERVAL)) begin
                m_cnt  = 0;
                m_pend = 1;
            end
        end
    endtask

    // Requester: holds req/len until the STP cycle, then offers the next packet
    task automatic drive_req();
        if (tlp_req && exp_sym == 4) tlp_req = 1'b0;
        if (!tlp_req) begin
            if (len_q.size() == 0 && rnd_mode && $urandom_range(0, 3) == 0)
                len_q.push_back(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30))
                                                            : int'($urandom_range(0, 6)));
            if (len_q.size() > 0) begin
                tlp_len = LEN_W'(len_q.pop_front());
                tlp_req = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("IN_CTRL", 32'(IN_CTRL), 32'(exp_sym));
        check("sym_k",   32'(sym_k),   32'(exp_sym != 0));
        check("tlp_ack", 32'(tlp_ack), 32'(exp_sym == 4));
        check("tlp_rd",  32'(tlp_rd),  32'(exp_sym == 0));
        check("busy",    32'(busy),    32'(exp_sym != 9));
        obs.push_back(int'(IN_CTRL));
        drive_req();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        ENB     = 1'b0;
        tlp_req = 1'b0;
        len_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        obs.delete();
    endtask

    // Asynchronous reset in the middle of a cycle, then release and hold check
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_ctrl", 32'(IN_CTRL), 32'd9);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_ack",  32'(tlp_ack), 32'd0);
        check("rst_rd",   32'(tlp_rd),  32'd0);
        check("rst_symk", 32'(sym_k),   32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_hold", 32'(IN_CTRL), 32'd9);
        check("rst_hold_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int pay_idx;
        reset    = 1'b1;
        ENB      = 1'b0;
        tlp_req  = 1'b0;
        tlp_len  = '0;
        rnd_mode = 0;
`ifdef PCIE_NULLIFY_EN
        tlp_abort = 1'b0;
`endif
        model_reset();

        // Single TLP, len 3
        do_reset();
        ENB = 1'b1;
        len_q.push_back(3);
        drive_req();
        repeat (6) cycle();
        foreach (EXP_SINGLE[i]) check_obs("single_seq", i, EXP_SINGLE[i]);

        // Back-to-back len 2 then len 1
        do_reset();
        ENB = 1'b1;
        len_q.push_back(2);
        len_q.push_back(1);
        drive_req();
        repeat (7) cycle();
        foreach (EXP_B2B[i]) check_obs("b2b_seq", i, EXP_B2B[i]);

        // Periodic SKP with no requests
        do_reset();
        ENB = 1'b1;
        repeat (40) cycle();
        check_obs("skp_idle", 15, 9);
        check_obs("skp_com1", 16, 1);
        for (int i = 17; i < 20; i++) check_obs("skp_sym1", i, 3);
        check_obs("skp_after", 20, 9);
        check_obs("skp_com2", 32, 1);
        for (int i = 33; i < 36; i++) check_obs("skp_sym2", i, 3);

        // SKP and TLP request meet at the same decision point
        do_reset();
        ENB = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i == 15) len_q.push_back(2);
            cycle();
        end
        check_obs("coll_com", 16, 1);
        check_obs("coll_skp", 19, 3);
        check_obs("coll_stp", 20, 4);
        check_obs("coll_end", 23, 6);

        // Reset in the middle of a packet
        do_reset();
        ENB = 1'b1;
        len_q.push_back(5);
        drive_req();
        repeat (3) cycle();
        mid_reset();
        repeat (10) cycle();

`ifdef PCIE_NULLIFY_EN
        // Abort on the second payload cycle turns END into EDB
        do_reset();
        ENB = 1'b1;
        len_q.push_back(4);
        drive_req();
        pay_idx = 0;
        repeat (6) begin
            cycle();
            if (exp_sym == 0) pay_idx++;
            tlp_abort = (exp_sym == 0 && pay_idx == 2);
        end
        tlp_abort = 1'b0;
        foreach (EXP_NULL[i]) check_obs("null_seq", i, EXP_NULL[i]);
`endif

        // Randomized traffic, enable gaps and occasional resets
        do_reset();
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            ENB = ($urandom_range(0, 15) != 0);
            if (i % 500 < 60) ENB = 1'b1;
            if ((i / 250) % 4 == 3) ENB = ($urandom_range(0, 2) != 0);
`ifdef PCIE_NULLIFY_EN
            tlp_abort = ($urandom_range(0, 9) == 0);
`endif
            if (i == 777 || i == 1555 || i == 2333) mid_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
